// File: rtl/calc_engine_pkg.sv
// Shared command/ALU/state encodings and small decode helpers for the infix calculator.
package calc_engine_pkg;
  localparam int IC_N = 5;
  localparam int AC_N = 2;

  localparam logic [IC_N-1:0] IC_NONE  = 5'd0;
  localparam logic [IC_N-1:0] IC_D0    = 5'd1;   // D0..DF occupy 1..16
  localparam logic [IC_N-1:0] IC_DF    = 5'd16;
  localparam logic [IC_N-1:0] IC_ADD   = 5'd17;
  localparam logic [IC_N-1:0] IC_SUB   = 5'd18;
  localparam logic [IC_N-1:0] IC_MUL   = 5'd19;
  localparam logic [IC_N-1:0] IC_DIV   = 5'd20;
  localparam logic [IC_N-1:0] IC_LP    = 5'd21;
  localparam logic [IC_N-1:0] IC_RP    = 5'd22;
  localparam logic [IC_N-1:0] IC_EQ    = 5'd23;
  localparam logic [IC_N-1:0] IC_BACK  = 5'd24;
  localparam logic [IC_N-1:0] IC_CLEAR = 5'd25;

  typedef enum logic [AC_N-1:0] {AC_ADD, AC_SUB, AC_MUL, AC_DIV} ac_op_t;
  typedef enum logic [1:0] {CE_IDLE, CE_REDUCE, CE_PUSHOP, CE_ERROR} ce_state_t;

  function automatic logic ic_is_digit(input logic [IC_N-1:0] c);
    return (c >= IC_D0) && (c <= IC_DF);
  endfunction

  function automatic logic ic_is_op(input logic [IC_N-1:0] c);
    return (c >= IC_ADD) && (c <= IC_DIV);
  endfunction

  function automatic logic [1:0] ic_prec(input logic [IC_N-1:0] c);
    if (c == IC_MUL || c == IC_DIV) return 2'd2;
    if (c == IC_ADD || c == IC_SUB) return 2'd1;
    return 2'd0;
  endfunction

  function automatic ac_op_t ic_to_ac(input logic [IC_N-1:0] c);
    case (c)
      IC_SUB:  return AC_SUB;
      IC_MUL:  return AC_MUL;
      IC_DIV:  return AC_DIV;
      default: return AC_ADD;
    endcase
  endfunction
endpackage

// File: rtl/calc_engine_stack.sv
// LIFO with combinational top/second views; pop2push replaces the top two entries with one.
module calc_stack #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_pop2push,
  input  logic          i_clear,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_top,
  output logic [W-1:0]  o_second,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);
  localparam int IW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_cm1;
  logic [CW-1:0] w_cm2;

  assign w_cm1    = r_count - CW'(1);
  assign w_cm2    = r_count - CW'(2);
  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_top    = o_empty ? '0 : r_mem[IW'(w_cm1)];
  assign o_second = (r_count < CW'(2)) ? '0 : r_mem[IW'(w_cm2)];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_pop2push && (r_count >= CW'(2))) begin
      r_mem[IW'(w_cm2)] <= i_data;
      r_count           <= w_cm1;
    end else if (i_push && !o_full) begin
      r_mem[IW'(r_count)] <= i_data;
      r_count             <= r_count + CW'(1);
    end else if (i_pop && !o_empty) begin
      r_count <= w_cm1;
    end
  end
endmodule

// File: rtl/calc_engine.sv
// Shunting-yard infix evaluator: keypad commands in, one reduction per cycle through an external ALU.
module calc_engine
  import calc_engine_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  parameter int RADIX = 10
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [IC_N-1:0] i_in_cmd,
  output logic            o_out_valid,
  output logic [DW-1:0]   o_out_data,
  output logic            o_out_err,
  output logic [DW-1:0]   o_out_num,
  output logic [DW-1:0]   o_al_a,
  output logic [DW-1:0]   o_al_b,
  output logic [AC_N-1:0] o_al_cmd,
  input  logic [DW-1:0]   i_al_c,
  input  logic            i_al_err
);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int DGW = $clog2(DW + 1);

  ce_state_t       r_state, w_state_next;
  logic [DW-1:0]   r_num, r_out_data;
  logic [DGW-1:0]  r_digits;
  logic            r_entering, r_out_valid;
  logic [IC_N-1:0] r_pend;

  logic w_d_push, w_d_pop2push, w_clear, w_o_push, w_o_pop;
  logic [DW-1:0]   w_d_din, w_d_top, w_d_second;
  logic [IC_N-1:0] w_o_din, w_o_top, w_o_second;
  logic w_d_full, w_d_empty, w_o_full, w_o_empty;
  logic [CW-1:0]   w_d_count, w_o_count;
  logic            w_unused_op;

  calc_stack #(.W(DW), .DEPTH(DEPTH)) u_data (
    .i_clk(i_clk), .i_rst(i_rst), .i_push(w_d_push), .i_pop(1'b0),
    .i_pop2push(w_d_pop2push), .i_clear(w_clear), .i_data(w_d_din),
    .o_top(w_d_top), .o_second(w_d_second), .o_full(w_d_full),
    .o_empty(w_d_empty), .o_count(w_d_count)
  );

  calc_stack #(.W(IC_N), .DEPTH(DEPTH)) u_op (
    .i_clk(i_clk), .i_rst(i_rst), .i_push(w_o_push), .i_pop(w_o_pop),
    .i_pop2push(1'b0), .i_clear(w_clear), .i_data(w_o_din),
    .o_top(w_o_top), .o_second(w_o_second), .o_full(w_o_full),
    .o_empty(w_o_empty), .o_count(w_o_count)
  );
  assign w_unused_op = ^{w_o_second, w_o_count};

  logic            w_accept, w_is_num_end, w_need_push, w_digit_ok, w_overflow;
  logic            w_can_reduce, w_red_bad, w_rp_ok, w_eq_ok;
  logic [3:0]      w_digit_val;
  logic [DW-1:0]   w_num_base;
  logic [DW+4:0]   w_num_ext;

  assign w_accept     = i_in_valid && o_in_ready;
  assign w_is_num_end = ic_is_op(i_in_cmd) || (i_in_cmd == IC_RP) || (i_in_cmd == IC_EQ);
  // An operator right after '=' (or clear) continues from the displayed number.
  assign w_need_push  = r_entering || (ic_is_op(i_in_cmd) && w_d_empty && w_o_empty);
  assign w_digit_val  = 4'(i_in_cmd - IC_D0);
  assign w_digit_ok   = ic_is_digit(i_in_cmd) && (int'(w_digit_val) < RADIX);
  assign w_num_base   = r_entering ? r_num : '0;
  assign w_num_ext    = (DW+5)'(w_num_base) * (DW+5)'(RADIX) + (DW+5)'(w_digit_val);
  // Entered literals are non-negative, so anything beyond the signed maximum overflows.
  assign w_overflow   = |w_num_ext[DW+4:DW-1];

  assign w_can_reduce = !w_o_empty && (w_o_top != IC_LP) &&
                        ((r_pend == IC_RP) || (r_pend == IC_EQ) || (ic_prec(w_o_top) >= ic_prec(r_pend)));
  assign w_red_bad    = (w_d_count < CW'(2)) || i_al_err;
  assign w_rp_ok      = !w_o_empty && (w_o_top == IC_LP);
  assign w_eq_ok      = w_o_empty && (w_d_count == CW'(1));

  assign o_al_a      = w_d_second;
  assign o_al_b      = w_d_top;
  assign o_al_cmd    = ic_to_ac(w_o_top);
  assign o_out_err   = (r_state == CE_ERROR);
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_num   = r_num;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= CE_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      CE_IDLE: if (w_accept) begin
        if (w_digit_ok && w_overflow)                    w_state_next = CE_ERROR;
        else if (i_in_cmd == IC_LP && w_o_full)          w_state_next = CE_ERROR;
        else if (w_is_num_end && w_need_push && w_d_full) w_state_next = CE_ERROR;
        else if (w_is_num_end)                           w_state_next = CE_REDUCE;
      end
      CE_REDUCE: begin
        if (!w_can_reduce)  w_state_next = CE_PUSHOP;
        else if (w_red_bad) w_state_next = CE_ERROR;
      end
      CE_PUSHOP: begin
        w_state_next = CE_IDLE;
        if (ic_is_op(r_pend) && w_o_full)         w_state_next = CE_ERROR;
        if ((r_pend == IC_RP) && !w_rp_ok)        w_state_next = CE_ERROR;
        if ((r_pend == IC_EQ) && !w_eq_ok)        w_state_next = CE_ERROR;
      end
      CE_ERROR: if (w_accept && i_in_cmd == IC_CLEAR) w_state_next = CE_IDLE;
      default:  w_state_next = CE_IDLE;
    endcase
  end

  always_comb begin
    o_in_ready   = 1'b0;
    w_d_push     = 1'b0;
    w_d_pop2push = 1'b0;
    w_clear      = 1'b0;
    w_o_push     = 1'b0;
    w_o_pop      = 1'b0;
    w_d_din      = r_num;
    w_o_din      = r_pend;
    case (r_state)
      CE_IDLE: begin
        o_in_ready = 1'b1;
        if (w_accept) begin
          if (i_in_cmd == IC_CLEAR) w_clear = 1'b1;
          if (i_in_cmd == IC_LP) begin
            w_o_push = !w_o_full;
            w_o_din  = IC_LP;
          end
          if (w_is_num_end) w_d_push = w_need_push && !w_d_full;
        end
      end
      CE_REDUCE: if (w_can_reduce && !w_red_bad) begin
        w_d_pop2push = 1'b1;
        w_d_din      = i_al_c;
        w_o_pop      = 1'b1;
      end
      CE_PUSHOP: begin
        if (ic_is_op(r_pend)) w_o_push = !w_o_full;
        if (r_pend == IC_RP)  w_o_pop  = w_rp_ok;
        if (r_pend == IC_EQ)  w_clear  = w_eq_ok;
      end
      CE_ERROR: begin
        o_in_ready = 1'b1;
        w_clear    = w_accept && (i_in_cmd == IC_CLEAR);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_num       <= '0;
      r_digits    <= '0;
      r_entering  <= 1'b0;
      r_pend      <= IC_NONE;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept && i_in_cmd == IC_CLEAR) begin
        r_num      <= '0;
        r_digits   <= '0;
        r_entering <= 1'b0;
        r_out_data <= '0;
      end else if (r_state == CE_IDLE && w_accept) begin
        if (w_digit_ok && !w_overflow) begin
          r_num      <= DW'(w_num_ext);
          r_digits   <= !r_entering ? DGW'(1) : ((&r_digits) ? r_digits : r_digits + DGW'(1));
          r_entering <= 1'b1;
        end else if (i_in_cmd == IC_BACK && r_entering) begin
          r_num    <= r_num / DW'(RADIX);
          r_digits <= r_digits - DGW'(1);
          if (r_digits == DGW'(1)) r_entering <= 1'b0;
        end else if (w_is_num_end) begin
          r_pend     <= i_in_cmd;
          r_entering <= 1'b0;
          r_digits   <= '0;
          if (r_entering) r_num <= '0;
        end
      end else if (r_state == CE_PUSHOP && r_pend == IC_EQ && w_eq_ok) begin
        r_out_data  <= w_d_top;
        r_out_valid <= 1'b1;
        r_num       <= w_d_top;
        r_entering  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_calc_engine.sv
// Directed scenarios for calc_engine with a behavioural signed ALU attached.
module tb_calc_engine;
  import calc_engine_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [IC_N-1:0] in_cmd;
  logic            in_ready, out_valid, out_err, al_err;
  logic [31:0]     out_data, out_num, al_a, al_b, al_c;
  logic [AC_N-1:0] al_cmd;

  int checks = 0;
  int failures = 0;
  int valid_cnt;
  logic [31:0] last_data;

  calc_engine #(.DW(32), .DEPTH(8), .RADIX(10)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_cmd(in_cmd), .o_out_valid(out_valid), .o_out_data(out_data),
    .o_out_err(out_err), .o_out_num(out_num), .o_al_a(al_a), .o_al_b(al_b),
    .o_al_cmd(al_cmd), .i_al_c(al_c), .i_al_err(al_err)
  );

  always #5 clk = ~clk;

  logic signed [63:0] alu_a, alu_b, alu_r;
  always_comb begin
    alu_a  = 64'(signed'(al_a));
    alu_b  = 64'(signed'(al_b));
    alu_r  = '0;
    al_err = 1'b0;
    case (al_cmd)
      AC_ADD: alu_r = alu_a + alu_b;
      AC_SUB: alu_r = alu_a - alu_b;
      AC_MUL: alu_r = alu_a * alu_b;
      default: begin
        if (alu_b == 0) al_err = 1'b1;
        else            alu_r  = alu_a / alu_b;
      end
    endcase
    if (alu_r > 64'sd2147483647 || alu_r < -64'sd2147483648) al_err = 1'b1;
    al_c = alu_r[31:0];
  end

  function automatic logic [IC_N-1:0] to_cmd(input byte c);
    if (c >= "0" && c <= "9") return IC_D0 + IC_N'(c - "0");
    case (c)
      "+": return IC_ADD;
      "-": return IC_SUB;
      "*": return IC_MUL;
      "/": return IC_DIV;
      "(": return IC_LP;
      ")": return IC_RP;
      "=": return IC_EQ;
      "B": return IC_BACK;
      "C": return IC_CLEAR;
      default: return IC_NONE;
    endcase
  endfunction

  task automatic send_cmd(input logic [IC_N-1:0] cmd);
    int waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout cmd=%0d in_ready=%b required=1", cmd, in_ready);
    end else begin
      in_valid = 1'b1;
      in_cmd   = cmd;
      @(negedge clk);
      in_valid = 1'b0;
      in_cmd   = IC_NONE;
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_cmd(to_cmd(s[i]));
  endtask

  // Sends a string then watches a window of cycles for result pulses.
  task automatic run_watch(input string s);
    valid_cnt = 0;
    send_str(s);
    for (int i = 0; i < 12; i++) begin
      if (out_valid) begin
        valid_cnt++;
        last_data = out_data;
      end
      @(negedge clk);
    end
  endtask

  task automatic expect_result(input string name, input logic [31:0] exp);
    checks++;
    if (valid_cnt != 1 || last_data !== exp) begin
      failures++;
      $display("FAIL %s pulses=%0d data=%0d required pulses=1 data=%0d", name, valid_cnt, signed'(last_data), signed'(exp));
    end
    checks++;
    if (out_err !== 1'b0) begin
      failures++;
      $display("FAIL %s_err got=%b required=0", name, out_err);
    end
    $display("txn %s result=%0d pulses=%0d", name, signed'(last_data), valid_cnt);
  endtask

  task automatic expect_err(input string name, input logic exp);
    checks++;
    if (out_err !== exp) begin
      failures++;
      $display("FAIL %s out_err=%b required=%b", name, out_err, exp);
    end
    $display("txn %s out_err=%b", name, out_err);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_cmd = IC_NONE;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_err !== 1'b0 || out_data !== 32'd0 || out_num !== 32'd0) begin
      failures++;
      $display("FAIL reset ready=%b valid=%b err=%b data=%0d num=%0d required 1 0 0 0 0",
               in_ready, out_valid, out_err, out_data, out_num);
    end
    $display("txn reset ready=%b err=%b", in_ready, out_err);
  endtask

  task automatic test_precedence();
    send_str("C12");
    checks++;
    if (out_num !== 32'd12) begin
      failures++;
      $display("FAIL entry_num got=%0d required=12", out_num);
    end
    run_watch("+3*4=");
    expect_result("prec_12+3*4", 32'd24);
  endtask

  task automatic test_parens_chain();
    run_watch("C(1+2)*3=");
    expect_result("parens", 32'd9);
    run_watch("+1=");
    expect_result("chain", 32'd10);
  endtask

  task automatic test_back();
    send_str("C123B");
    checks++;
    if (out_num !== 32'd12) begin
      failures++;
      $display("FAIL back_num got=%0d required=12", out_num);
    end
    run_watch("+4=");
    expect_result("back_sum", 32'd16);
  endtask

  task automatic test_left_assoc();
    run_watch("C9-8-7=");
    expect_result("sub_assoc", 32'hFFFF_FFFA);
    run_watch("C8/2/2=");
    expect_result("div_assoc", 32'd2);
  endtask

  task automatic test_div_zero();
    run_watch("C5/0=");
    expect_err("div0", 1'b1);
    checks++;
    if (in_ready !== 1'b1 || valid_cnt != 0) begin
      failures++;
      $display("FAIL div0_state ready=%b pulses=%0d required 1 0", in_ready, valid_cnt);
    end
    run_watch("7=");
    expect_err("dropped", 1'b1);
    checks++;
    if (valid_cnt != 0) begin
      failures++;
      $display("FAIL dropped_pulses got=%0d required=0", valid_cnt);
    end
    send_str("C");
    expect_err("clear", 1'b0);
    run_watch("2=");
    expect_result("after_clear", 32'd2);
  endtask

  task automatic test_errors();
    send_str("C((((((((");
    expect_err("lp_8", 1'b0);
    send_str("(");
    expect_err("lp_9", 1'b1);
    run_watch("C1+2)");
    expect_err("unmatched_rp", 1'b1);
    run_watch("C(1=");
    expect_err("open_lp_eq", 1'b1);
    run_watch("C=");
    expect_err("empty_eq", 1'b1);
    send_str("C");
  endtask

  task automatic test_reset_mid();
    send_str("C9-8-7");
    send_cmd(IC_EQ);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_err !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'd0 || out_num !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid ready=%b err=%b valid=%b data=%0d num=%0d required 1 0 0 0 0",
               in_ready, out_err, out_valid, out_data, out_num);
    end
    run_watch("");
    checks++;
    if (valid_cnt != 0) begin
      failures++;
      $display("FAIL reset_mid_pulse got=%0d required=0", valid_cnt);
    end
    run_watch("=");
    expect_err("reset_mid_empty", 1'b1);
    run_watch("C3=");
    expect_result("reset_mid_recover", 32'd3);
  endtask

  initial begin
    test_reset();
    test_precedence();
    test_parens_chain();
    test_back();
    test_left_assoc();
    test_div_zero();
    test_errors();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
